// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, instruction field widths and
// the fetch sequencer state encoding.
package cpu_pkg;

  // Default PC/ROM address width and instruction width.
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_INSTR_W = 8;

  // Instruction fields: [7:4] opcode, [3:0] operand.
  localparam int OPCODE_W  = 4;
  localparam int OPERAND_W = 4;

  // Opcodes that the sequencer itself interprets. ALU opcodes are added here
  // as the datapath grows; the sequencer treats them all as "advance PC".
  localparam logic [OPCODE_W-1:0] OP_JMP  = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_HALT = 4'hF;

  // Fetch sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/prog_rom.sv
// Program store: register array with synchronous write and combinational
// read. Contents are deliberately not reset so a loaded program survives rst.
module prog_rom #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Program-load write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read is combinational; the instruction register in the sequencer
  // provides the pipeline register.
  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch/decode stage: FETCH -> DECODE -> EXEC sequencer that latches the
// ROM word at the current PC into the instruction register and tells the
// PC block when to increment, when to jump, and when the CPU has halted.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    PC_CURR,
  input  logic                 PROG_WE,
  input  logic [ADDR_W-1:0]    PROG_ADDR,
  input  logic [INSTR_W-1:0]   PROG_DATA,
  input  logic                 START,
  output logic                 PC_INC,
  output logic                 PC_LOAD,
  output logic [ADDR_W-1:0]    PC_TARGET,
  output logic [INSTR_W-1:0]   INSTR,
  output logic [OPCODE_W-1:0]  OPCODE,
  output logic [OPERAND_W-1:0] OPERAND,
  output logic                 IR_VALID,
  output logic                 HALTED
);

  fetch_state_t         state_reg, state_next;
  logic [INSTR_W-1:0]   instr_reg;
  logic [INSTR_W-1:0]   rom_rdata;
  logic                 rom_we;
  logic                 pc_inc_reg, pc_load_reg, ir_valid_reg, halted_reg;
  logic [ADDR_W-1:0]    pc_target_reg;
  logic [OPCODE_W-1:0]  opcode;
  logic [OPERAND_W-1:0] operand;
  logic                 entering_exec;
  logic                 is_jump;

  assign opcode  = instr_reg[INSTR_W-1 -: OPCODE_W];
  assign operand = instr_reg[OPERAND_W-1:0];
  assign is_jump = (opcode == OP_JMP);

  // Programming is only allowed while the sequencer is not fetching, so a
  // write can never collide with an instruction read.
  assign rom_we = PROG_WE && ((state_reg == ST_IDLE) || (state_reg == ST_HALTED));

  prog_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (INSTR_W)
  ) u_prog_rom (
    .clk   (clk),
    .we    (rom_we),
    .waddr (PROG_ADDR),
    .wdata (PROG_DATA),
    .raddr (PC_CURR),
    .rdata (rom_rdata)
  );

  // Next-state logic; START is only looked at in IDLE and HALTED.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (START) state_next = ST_FETCH;
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: state_next = (opcode == OP_HALT) ? ST_HALTED : ST_EXEC;
      ST_EXEC:   state_next = ST_FETCH;
      ST_HALTED: if (START) state_next = ST_FETCH;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign entering_exec = (state_next == ST_EXEC);

  // State register, instruction register and registered Moore outputs; the
  // outputs are computed from the next state so they are high exactly for
  // the cycle spent in EXEC / HALTED.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      instr_reg     <= '0;
      pc_inc_reg    <= 1'b0;
      pc_load_reg   <= 1'b0;
      ir_valid_reg  <= 1'b0;
      halted_reg    <= 1'b0;
      pc_target_reg <= '0;
    end else begin
      state_reg    <= state_next;
      if (state_reg == ST_FETCH) begin
        instr_reg <= rom_rdata;
      end
      ir_valid_reg <= entering_exec;
      pc_inc_reg   <= entering_exec && !is_jump;
      pc_load_reg  <= entering_exec && is_jump;
      halted_reg   <= (state_next == ST_HALTED);
      if (entering_exec && is_jump) begin
        pc_target_reg <= ADDR_W'(operand);
      end
    end
  end

  // A reset arriving during EXEC must stop the PC from moving on that same
  // edge, so the PC pulses are suppressed while rst is high.
  assign PC_INC    = pc_inc_reg  && !rst;
  assign PC_LOAD   = pc_load_reg && !rst;
  assign PC_TARGET = pc_target_reg;
  assign INSTR     = instr_reg;
  assign OPCODE    = opcode;
  assign OPERAND   = operand;
  assign IR_VALID  = ir_valid_reg;
  assign HALTED    = halted_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: a small PC model drives PC_CURR, expected EXEC
// transactions are queued when a program is set up and compared as the DUT
// presents each IR_VALID cycle.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] PC_CURR;
  logic       PROG_WE;
  logic [3:0] PROG_ADDR;
  logic [7:0] PROG_DATA;
  logic       START;
  logic       PC_INC, PC_LOAD;
  logic [3:0] PC_TARGET;
  logic [7:0] INSTR;
  logic [3:0] OPCODE, OPERAND;
  logic       IR_VALID, HALTED;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .PC_CURR   (PC_CURR),
    .PROG_WE   (PROG_WE),
    .PROG_ADDR (PROG_ADDR),
    .PROG_DATA (PROG_DATA),
    .START     (START),
    .PC_INC    (PC_INC),
    .PC_LOAD   (PC_LOAD),
    .PC_TARGET (PC_TARGET),
    .INSTR     (INSTR),
    .OPCODE    (OPCODE),
    .OPERAND   (OPERAND),
    .IR_VALID  (IR_VALID),
    .HALTED    (HALTED)
  );

  // PC block model: external set has priority, then jump, then increment.
  logic [3:0] pc_model;
  logic       set_pc_en;
  logic [3:0] set_pc_val;

  always @(posedge clk) begin
    if (set_pc_en)    pc_model <= set_pc_val;
    else if (PC_LOAD) pc_model <= PC_TARGET;
    else if (PC_INC)  pc_model <= pc_model + 4'd1;
  end
  assign PC_CURR = pc_model;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] instr;
    logic       inc;
    logic       load;
    logic [3:0] target;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_exp(input logic [7:0] instr, input logic inc, input logic load,
                          input logic [3:0] target);
    exp_t e;
    e.instr = instr; e.inc = inc; e.load = load; e.target = target;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every EXEC cycle must match the next queued
  // expectation; outside EXEC no PC pulse may appear.
  always @(negedge clk) begin
    exp_t e;
    if (IR_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_exec", 32'(INSTR), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("exec_instr",   32'(INSTR),   32'(e.instr));
        check("exec_opcode",  32'(OPCODE),  32'(e.instr[7:4]));
        check("exec_operand", 32'(OPERAND), 32'(e.instr[3:0]));
        check("exec_pc_inc",  32'(PC_INC),  32'(e.inc));
        check("exec_pc_load", 32'(PC_LOAD), 32'(e.load));
        if (e.load) check("exec_pc_target", 32'(PC_TARGET), 32'(e.target));
        $display("EXEC instr=%02h inc=%0b load=%0b target=%0h pc=%0h",
                 INSTR, PC_INC, PC_LOAD, PC_TARGET, pc_model);
      end
    end else if (rst === 1'b0) begin
      check("no_pulse_outside_exec", 32'({PC_INC, PC_LOAD}), 32'h0);
    end
  end

  task automatic rom_write(input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    PROG_WE = 1'b1; PROG_ADDR = addr; PROG_DATA = data;
    @(negedge clk);
    PROG_WE = 1'b0;
    $display("LOAD rom[%0h]=%02h", addr, data);
  endtask

  task automatic set_pc(input logic [3:0] v);
    @(negedge clk);
    set_pc_en = 1'b1; set_pc_val = v;
    @(negedge clk);
    set_pc_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n = 0;
    while (HALTED !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(HALTED), 32'h1);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'h0);
    $display("HALT %s pc=%0h instr=%02h cycles=%0d", tag, pc_model, INSTR, n);
  endtask

  task automatic wait_exec(input string tag, input int budget);
    int n = 0;
    while (IR_VALID !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(IR_VALID), 32'h1);
  endtask

  initial begin
    rst = 1'b1; START = 1'b0; PROG_WE = 1'b0; PROG_ADDR = '0; PROG_DATA = '0;
    set_pc_en = 1'b0; set_pc_val = '0;

    // Reset for two clocks.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_instr",     32'(INSTR),     32'h00);
    check("reset_pc_inc",    32'(PC_INC),    32'h0);
    check("reset_pc_load",   32'(PC_LOAD),   32'h0);
    check("reset_ir_valid",  32'(IR_VALID),  32'h0);
    check("reset_halted",    32'(HALTED),    32'h0);
    check("reset_pc_target", 32'(PC_TARGET), 32'h0);

    // Straight-line program ending in HALT.
    rom_write(4'h0, 8'h13);
    rom_write(4'h1, 8'h25);
    rom_write(4'h2, 8'hF0);
    set_pc(4'h0);
    push_exp(8'h13, 1'b1, 1'b0, 4'h0);
    push_exp(8'h25, 1'b1, 1'b0, 4'h0);
    pulse_start();
    wait_halt("seq_halt", 40);
    check("seq_pc",      32'(pc_model), 32'h2);
    check("seq_instr",   32'(INSTR),    32'hF0);
    check("seq_opcode",  32'(OPCODE),   32'hF);
    check("seq_ir_low",  32'(IR_VALID), 32'h0);

    // Jump to 5, which holds HALT (loaded while HALTED).
    rom_write(4'h0, 8'hE5);
    rom_write(4'h5, 8'hF0);
    set_pc(4'h0);
    push_exp(8'hE5, 1'b0, 1'b1, 4'h5);
    pulse_start();
    wait_halt("jmp_halt", 40);
    check("jmp_pc",    32'(pc_model), 32'h5);
    check("jmp_instr", 32'(INSTR),    32'hF0);

    // Program write attempted during EXEC must be ignored.
    rom_write(4'h0, 8'h11);
    rom_write(4'h1, 8'hF0);
    rom_write(4'h3, 8'h33);
    rom_write(4'h4, 8'hF0);
    set_pc(4'h0);
    push_exp(8'h11, 1'b1, 1'b0, 4'h0);
    pulse_start();
    wait_exec("we_exec_seen", 20);
    PROG_WE = 1'b1; PROG_ADDR = 4'h3; PROG_DATA = 8'hAA;
    @(negedge clk);
    PROG_WE = 1'b0;
    wait_halt("we_halt", 40);
    set_pc(4'h3);
    push_exp(8'h33, 1'b1, 1'b0, 4'h0);
    pulse_start();
    wait_halt("we_readback_halt", 40);
    check("we_pc", 32'(pc_model), 32'h4);

    // Reset during EXEC of a non-jump drops the PC_INC pulse.
    rom_write(4'h0, 8'h22);
    rom_write(4'h1, 8'hF0);
    set_pc(4'h0);
    push_exp(8'h22, 1'b1, 1'b0, 4'h0);
    pulse_start();
    wait_exec("rst_exec_seen", 20);
    #2 rst = 1'b1;
    #1;
    check("rst_exec_pc_inc",  32'(PC_INC),  32'h0);
    check("rst_exec_pc_load", 32'(PC_LOAD), 32'h0);
    @(negedge clk);
    check("rst_pc_held",   32'(pc_model), 32'h0);
    check("rst_ir_valid",  32'(IR_VALID), 32'h0);
    check("rst_halted",    32'(HALTED),   32'h0);
    check("rst_instr",     32'(INSTR),    32'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_idle_stays", 32'({IR_VALID, HALTED}), 32'h0);
    $display("RESET in EXEC pc=%0h instr=%02h", pc_model, INSTR);

    // Wrap: instruction at 15 increments PC to 0, which holds HALT.
    rom_write(4'hF, 8'h11);
    rom_write(4'h0, 8'hF0);
    set_pc(4'hF);
    push_exp(8'h11, 1'b1, 1'b0, 4'h0);
    pulse_start();
    wait_halt("wrap_halt", 40);
    check("wrap_pc",    32'(pc_model), 32'h0);
    check("wrap_instr", 32'(INSTR),    32'hF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
